// File: rtl/regfile_pkg.sv
// Shared write-back select encoding and legality check for the register file.
package regfile_pkg;

    localparam int WB_SEL_W = 3;

    localparam logic [WB_SEL_W-1:0] WB_RAM   = 3'd0;
    localparam logic [WB_SEL_W-1:0] WB_ALU   = 3'd1;
    localparam logic [WB_SEL_W-1:0] WB_HI    = 3'd2;
    localparam logic [WB_SEL_W-1:0] WB_LO    = 3'd3;
    localparam logic [WB_SEL_W-1:0] WB_CONST = 3'd4;

    function automatic logic wb_sel_legal(input logic [WB_SEL_W-1:0] sel);
        return (sel <= WB_CONST);
    endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// One pending bit per register: set when a long-latency result is issued,
// cleared when its write-back lands.
module busy_scoreboard #(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_d, busy_q;

    // Set is applied after clear so a freshly issued load wins over a
    // write-back retiring the previous result to the same register.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-back mux, HI/LO holding
// registers, optional write bypass and a busy scoreboard driving stall.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW      = 16,
    parameter int NREG    = 8,
    parameter int AW      = $clog2(NREG),
    parameter int R0_ZERO = 0,
    parameter int BYPASS  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       rs_addr,
    input  logic [AW-1:0]       rt_addr,
    input  logic                rs_use,
    input  logic                rt_use,
    output logic [DW-1:0]       rs_data,
    output logic [DW-1:0]       rt_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WB_SEL_W-1:0] wr_sel,
    input  logic [DW-1:0]       alu_data,
    input  logic [DW-1:0]       ram_data,
    input  logic [DW-1:0]       const_data,
    input  logic                hilo_en,
    input  logic [DW-1:0]       hi_in,
    input  logic [DW-1:0]       lo_in,
    output logic [DW-1:0]       hi_out,
    output logic [DW-1:0]       lo_out,
    input  logic                busy_set,
    input  logic [AW-1:0]       busy_addr,
    output logic [NREG-1:0]     busy_vec,
    output logic                stall,
    output logic                sel_err
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0] wr_data;
    logic          sel_err_q, sel_err_d;
    logic          sel_ok, r0_drop, wr_ok, set_ok, fwd_rs, fwd_rt;

    // HI/LO sources read the registered values, so a same-cycle HI/LO
    // load never leaks into the write-back.
    always_comb begin
        case (wr_sel)
            WB_RAM:   wr_data = ram_data;
            WB_ALU:   wr_data = alu_data;
            WB_HI:    wr_data = hi_q;
            WB_LO:    wr_data = lo_q;
            WB_CONST: wr_data = const_data;
            default:  wr_data = '0;
        endcase
    end

    assign sel_ok  = wb_sel_legal(wr_sel);
    assign r0_drop = (R0_ZERO != 0) && (wr_addr == '0);
    assign wr_ok   = wr_en && sel_ok && !r0_drop;
    assign set_ok  = busy_set && !((R0_ZERO != 0) && (busy_addr == '0));
    assign fwd_rs  = (BYPASS != 0) && wr_ok && (wr_addr == rs_addr);
    assign fwd_rt  = (BYPASS != 0) && wr_ok && (wr_addr == rt_addr);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) regs_d[wr_addr] = wr_data;
        hi_d      = hilo_en ? hi_in : hi_q;
        lo_d      = hilo_en ? lo_in : lo_q;
        sel_err_d = wr_en && !sel_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q    <= '{default: '0};
            hi_q      <= '0;
            lo_q      <= '0;
            sel_err_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
        if ((R0_ZERO != 0) && (rs_addr == '0)) rs_data = '0;
        if ((R0_ZERO != 0) && (rt_addr == '0)) rt_data = '0;
        if (fwd_rs) rs_data = wr_data;
        if (fwd_rt) rt_data = wr_data;
    end

    busy_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_busy (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_ok),
        .set_addr (busy_addr),
        .clr_en   (wr_ok),
        .clr_addr (wr_addr),
        .busy_vec (busy_vec)
    );

    // A forwarded write resolves the hazard in the same cycle it lands.
    assign stall   = (rs_use & busy_vec[rs_addr] & ~fwd_rs)
                   | (rt_use & busy_vec[rt_addr] & ~fwd_rt);
    assign hi_out  = hi_q;
    assign lo_out  = lo_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: instance a (bypass, r0 writable) and instance b
// (no bypass, r0 hardwired) share stimulus; expectations go through a queue.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  rs_addr = '0, rt_addr = '0, wr_addr = '0, busy_addr = '0;
    logic        rs_use = 1'b0, rt_use = 1'b0, wr_en = 1'b0, hilo_en = 1'b0, busy_set = 1'b0;
    logic [2:0]  wr_sel = '0;
    logic [15:0] alu_data = '0, ram_data = '0, const_data = '0, hi_in = '0, lo_in = '0;

    logic [15:0] a_rs, a_rt, a_hi, a_lo, b_rs, b_rt, b_hi, b_lo;
    logic [7:0]  a_busy, b_busy;
    logic        a_stall, b_stall, a_serr, b_serr;

    typedef struct { string name; logic [31:0] exp; } exp_t;
    exp_t        sb_q[$];
    logic [31:0] obs_q[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    regfile_sb #(.R0_ZERO(0), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_use(rs_use), .rt_use(rt_use),
        .rs_data(a_rs), .rt_data(a_rt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .alu_data(alu_data), .ram_data(ram_data), .const_data(const_data), .hilo_en(hilo_en),
        .hi_in(hi_in), .lo_in(lo_in), .hi_out(a_hi), .lo_out(a_lo), .busy_set(busy_set),
        .busy_addr(busy_addr), .busy_vec(a_busy), .stall(a_stall), .sel_err(a_serr)
    );

    regfile_sb #(.R0_ZERO(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_use(rs_use), .rt_use(rt_use),
        .rs_data(b_rs), .rt_data(b_rt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .alu_data(alu_data), .ram_data(ram_data), .const_data(const_data), .hilo_en(hilo_en),
        .hi_in(hi_in), .lo_in(lo_in), .hi_out(b_hi), .lo_out(b_lo), .busy_set(busy_set),
        .busy_addr(busy_addr), .busy_vec(b_busy), .stall(b_stall), .sel_err(b_serr)
    );

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Start a new cycle just after the rising edge with all strobes idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        wr_en = 1'b0; hilo_en = 1'b0; busy_set = 1'b0;
    endtask

    task automatic exp(input string name, input logic [31:0] v);
        sb_q.push_back('{name, v});
    endtask

    task automatic test_reset();
        rs_addr = 3'd3; rt_addr = 3'd5;
        exp("rst_a_rs", 0); exp("rst_a_rt", 0); exp("rst_a_busy", 0); exp("rst_a_stall", 0);
        exp("rst_a_hi", 0); exp("rst_a_lo", 0); exp("rst_a_selerr", 0); exp("rst_b_busy", 0);
        @(negedge clk);
        obs_q.push_back(32'(a_rs)); obs_q.push_back(32'(a_rt)); obs_q.push_back(32'(a_busy));
        obs_q.push_back(32'(a_stall)); obs_q.push_back(32'(a_hi)); obs_q.push_back(32'(a_lo));
        obs_q.push_back(32'(a_serr)); obs_q.push_back(32'(b_busy));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_write_bypass();
        next_cycle();
        wr_en = 1'b1; wr_addr = 3'd3; wr_sel = 3'd1; alu_data = 16'h1234; rs_addr = 3'd3;
        exp("byp_a_rs_same", 32'h1234); exp("byp_b_rs_same", 32'h0000);
        @(negedge clk);
        obs_q.push_back(32'(a_rs)); obs_q.push_back(32'(b_rs));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        next_cycle();
        exp("byp_a_rs_next", 32'h1234); exp("byp_b_rs_next", 32'h1234);
        @(negedge clk);
        obs_q.push_back(32'(a_rs)); obs_q.push_back(32'(b_rs));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
    endtask

    task automatic test_hilo();
        next_cycle();
        hilo_en = 1'b1; hi_in = 16'hAAAA; lo_in = 16'h5555;
        wr_en = 1'b1; wr_addr = 3'd2; wr_sel = 3'd2; rs_addr = 3'd2;
        exp("hilo_a_r2_oldhi", 32'h0000); exp("hilo_a_hi_pre", 32'h0000);
        @(negedge clk);
        obs_q.push_back(32'(a_rs)); obs_q.push_back(32'(a_hi));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        next_cycle();
        wr_en = 1'b1; wr_addr = 3'd6; wr_sel = 3'd3; rs_addr = 3'd2; rt_addr = 3'd6;
        exp("hilo_a_hi", 32'hAAAA); exp("hilo_a_lo", 32'h5555); exp("hilo_a_r2", 32'h0000);
        exp("hilo_a_r6_byp", 32'h5555); exp("hilo_b_r6_same", 32'h0000);
        @(negedge clk);
        obs_q.push_back(32'(a_hi)); obs_q.push_back(32'(a_lo)); obs_q.push_back(32'(a_rs));
        obs_q.push_back(32'(a_rt)); obs_q.push_back(32'(b_rt));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        next_cycle();
        exp("hilo_b_r6", 32'h5555); exp("hilo_b_r2", 32'h0000); exp("hilo_b_hi", 32'hAAAA);
        @(negedge clk);
        obs_q.push_back(32'(b_rt)); obs_q.push_back(32'(b_rs)); obs_q.push_back(32'(b_hi));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
    endtask

    task automatic test_r0();
        next_cycle();
        wr_en = 1'b1; wr_addr = 3'd0; wr_sel = 3'd4; const_data = 16'hBEEF;
        busy_set = 1'b1; busy_addr = 3'd0; rs_addr = 3'd0;
        exp("r0_a_rs_byp", 32'hBEEF); exp("r0_b_rs_same", 32'h0000);
        @(negedge clk);
        obs_q.push_back(32'(a_rs)); obs_q.push_back(32'(b_rs));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        // Second write (no busy_set) retires a's r0 pending bit.
        next_cycle();
        wr_en = 1'b1; wr_addr = 3'd0; wr_sel = 3'd4;
        exp("r0_a_busy0_set", 1); exp("r0_b_busy0", 0); exp("r0_b_rs", 32'h0000);
        @(negedge clk);
        obs_q.push_back(32'(a_busy[0])); obs_q.push_back(32'(b_busy[0])); obs_q.push_back(32'(b_rs));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        next_cycle();
        exp("r0_a_busy0_clr", 0); exp("r0_a_rs", 32'hBEEF); exp("r0_b_rs_after", 32'h0000);
        @(negedge clk);
        obs_q.push_back(32'(a_busy[0])); obs_q.push_back(32'(a_rs)); obs_q.push_back(32'(b_rs));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
    endtask

    task automatic test_stall();
        next_cycle();
        busy_set = 1'b1; busy_addr = 3'd5; rs_addr = 3'd5; rs_use = 1'b1;
        exp("stl_a_stall_setcyc", 0);
        @(negedge clk);
        obs_q.push_back(32'(a_stall));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        next_cycle();
        exp("stl_a_stall", 1); exp("stl_b_stall", 1); exp("stl_a_busy5", 1);
        @(negedge clk);
        obs_q.push_back(32'(a_stall)); obs_q.push_back(32'(b_stall)); obs_q.push_back(32'(a_busy[5]));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        next_cycle();
        wr_en = 1'b1; wr_addr = 3'd5; wr_sel = 3'd0; ram_data = 16'h00FF;
        exp("stl_a_stall_wr", 0); exp("stl_a_rs_wr", 32'h00FF); exp("stl_b_stall_wr", 1);
        @(negedge clk);
        obs_q.push_back(32'(a_stall)); obs_q.push_back(32'(a_rs)); obs_q.push_back(32'(b_stall));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        next_cycle();
        exp("stl_a_stall_after", 0); exp("stl_b_stall_after", 0); exp("stl_a_busy5_clr", 0);
        exp("stl_b_rs_after", 32'h00FF);
        @(negedge clk);
        obs_q.push_back(32'(a_stall)); obs_q.push_back(32'(b_stall)); obs_q.push_back(32'(a_busy[5]));
        obs_q.push_back(32'(b_rs));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        rs_use = 1'b0;
    endtask

    task automatic test_set_clear();
        next_cycle();
        busy_set = 1'b1; busy_addr = 3'd4;
        wr_en = 1'b1; wr_addr = 3'd4; wr_sel = 3'd1; alu_data = 16'h4444; rs_addr = 3'd4;
        @(negedge clk);
        next_cycle();
        rs_use = 1'b1;
        exp("sc_a_busy4", 1); exp("sc_b_busy4", 1); exp("sc_a_r4", 32'h4444);
        exp("sc_b_r4", 32'h4444); exp("sc_a_stall", 1); exp("sc_b_stall", 1);
        @(negedge clk);
        obs_q.push_back(32'(a_busy[4])); obs_q.push_back(32'(b_busy[4])); obs_q.push_back(32'(a_rs));
        obs_q.push_back(32'(b_rs)); obs_q.push_back(32'(a_stall)); obs_q.push_back(32'(b_stall));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        rs_use = 1'b0;
    endtask

    task automatic test_sel_err();
        next_cycle();
        wr_en = 1'b1; wr_addr = 3'd1; wr_sel = 3'd1; alu_data = 16'h0007; rs_addr = 3'd1;
        @(negedge clk);
        next_cycle();
        wr_en = 1'b1; wr_addr = 3'd1; wr_sel = 3'd6; alu_data = 16'hDEAD;
        exp("se_a_rs_nobyp", 32'h0007); exp("se_a_err_same", 0);
        @(negedge clk);
        obs_q.push_back(32'(a_rs)); obs_q.push_back(32'(a_serr));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        next_cycle();
        wr_sel = 3'd1;
        exp("se_a_err", 1); exp("se_b_err", 1); exp("se_a_r1", 32'h0007); exp("se_b_r1", 32'h0007);
        @(negedge clk);
        obs_q.push_back(32'(a_serr)); obs_q.push_back(32'(b_serr)); obs_q.push_back(32'(a_rs));
        obs_q.push_back(32'(b_rs));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        next_cycle();
        exp("se_a_err_drop", 0); exp("se_b_err_drop", 0);
        @(negedge clk);
        obs_q.push_back(32'(a_serr)); obs_q.push_back(32'(b_serr));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
    endtask

    task automatic test_reset_mid_stall();
        next_cycle();
        rs_addr = 3'd4; rs_use = 1'b1;
        exp("mr_a_stall_pre", 1); exp("mr_a_busy_pre", 32'h10);
        @(negedge clk);
        obs_q.push_back(32'(a_stall)); obs_q.push_back(32'(a_busy));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        #1 rst = 1'b1;
        exp("mr_a_busy", 0); exp("mr_b_busy", 0); exp("mr_a_stall", 0); exp("mr_b_stall", 0);
        exp("mr_a_rs", 0); exp("mr_a_lo", 0);
        #1;
        obs_q.push_back(32'(a_busy)); obs_q.push_back(32'(b_busy)); obs_q.push_back(32'(a_stall));
        obs_q.push_back(32'(b_stall)); obs_q.push_back(32'(a_rs)); obs_q.push_back(32'(a_lo));
        while (sb_q.size() > 0) begin
            exp_t e; logic [31:0] o; e = sb_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e.exp) begin bad++; $display("FAIL %s actual=%h required=%h", e.name, o, e.exp); end
        end
        #1 rst = 1'b0;
        rs_use = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_hilo();
        test_r0();
        test_stall();
        test_set_clear();
        test_sel_err();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with write-back source mux, HI/LO holding registers, optional same-cycle write bypass and a per-register busy scoreboard for long-latency results such as RAM loads. It sits between decode and execute in the 16-bit processor. It provides two combinational read ports and one write port. It raises `stall` when an instruction reads a register whose result is still pending.

## Interface
Parameters:
- `DW`, 16, data width of registers, HI, LO and all data ports.
- `NREG`, 8, number of general registers; must be a power of two and at least 2.
- `AW`, $clog2(NREG), register address width (derived).
- `R0_ZERO`, 0, when 1, r0 reads as 0 and ignores writes and busy sets.
- `BYPASS`, 1, when 1, same-cycle write data is forwarded to the read ports.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rs_addr`, `rt_addr`  in  AW  read addresses.
- `rs_use`, `rt_use`  in  1  the current instruction actually reads rs / rt.
- `rs_data`, `rt_data`  out  DW  read data.
- `wr_en`  in  1  write-back strobe.
- `wr_addr`  in  AW  write-back destination.
- `wr_sel`  in  3  write-back source select.
- `alu_data`, `ram_data`, `const_data`  in  DW  write-back sources.
- `hilo_en`  in  1  load HI/LO.
- `hi_in`, `lo_in`  in  DW  HI/LO load data.
- `hi_out`, `lo_out`  out  DW  current HI/LO values.
- `busy_set`  in  1  mark `busy_addr` as pending.
- `busy_addr`  in  AW  register to mark as pending.
- `busy_vec`  out  NREG  scoreboard bits.
- `stall`  out  1  read hazard on a pending register.
- `sel_err`  out  1  registered one-cycle pulse on an illegal `wr_sel`.

## Operation
- Write-back mux (`wr_data`):
  - `wr_sel` 0 selects RAM, 1 ALU, 2 HI register, 3 LO register, 4 const.
  - Values 5–7 are illegal: the write is suppressed and `sel_err` goes to 1 for one cycle. `wr_data` is 0 in that case; no latch is inferred.
- Write: on a rising edge with `wr_en` set and a legal `wr_sel`, `regs[wr_addr] <= wr_data`. If `R0_ZERO=1` and `wr_addr==0`, the write is dropped.
- HI/LO: on a rising edge with `hilo_en` set, `hi <= hi_in` and `lo <= lo_in`. `wr_sel` 2/3 always use the pre-edge HI/LO value, even when `hilo_en` is set in the same cycle.
- Read:
  - `rs_data = regs[rs_addr]`, combinational; `rt_data` likewise.
  - With `R0_ZERO=1`, address 0 reads 0.
  - With `BYPASS=1`, a valid same-cycle write (`wr_en`, legal select, `wr_addr` equal to the read address, not a suppressed r0 write) returns `wr_data` instead.
- Scoreboard:
  - `busy_set` sets `busy_vec[busy_addr]` on the rising edge.
  - A valid write clears `busy_vec[wr_addr]`.
  - Set and clear on the same address in the same cycle: set wins, because a new load was issued.
  - With `R0_ZERO=1`, bit 0 is never set.
- Stall: `stall = (rs_use & busy[rs_addr] & ~fwd_rs) | (rt_use & busy[rt_addr] & ~fwd_rt)`.
  - `fwd_x` is 1 only when `BYPASS=1` and a valid write to that address occurs in this cycle.
  - With `BYPASS=0`, the stall holds through the write cycle and drops the cycle after.
- `rs_data` and `rt_data` carry stale data whenever `stall` is 1; consumers must not use them.

## Timing
- Reset (asynchronous): all registers 0, HI = LO = 0, `busy_vec` = 0, `sel_err` = 0. Therefore `stall` = 0 and all read data = 0.
- Write-to-read latency: 0 cycles with `BYPASS=1`, 1 cycle otherwise.
- HI/LO load is visible on `hi_out`/`lo_out` 1 cycle after the load edge.
- `busy_set` is visible in `busy_vec`/`stall` the cycle after its edge.
- `sel_err` asserts the cycle after the illegal write attempt and stays high for exactly 1 cycle per attempt.
- Reset asserted mid-operation clears pending busy bits immediately. Any write in flight is lost.

## Structure
- Package `regfile_pkg` holds:
  - the `wr_sel` constants `WB_RAM`=0, `WB_ALU`=1, `WB_HI`=2, `WB_LO`=3, `WB_CONST`=4;
  - the `WB_SEL_W`=3 constant;
  - the legality function `wb_sel_legal`.
- Sub-module `busy_scoreboard`, with parameters `NREG` and `AW`. It has set/clear ports and the busy vector output, and implements the set-over-clear priority. Everything else stays in `regfile_sb`.

## Test plan
- Reset, then write ALU=0x1234 to r3 with `wr_sel`=1 → `rs_data`=0x1234 in the same cycle with `BYPASS=1`; with `BYPASS=0`, 0x0000 in that cycle and 0x1234 the next.
- `hilo_en` with HI=0xAAAA, LO=0x5555 while writing r2 with `wr_sel`=2 in the same cycle → r2 = old HI (0x0000); the following write with `wr_sel`=3 → LO value 0x5555.
- `R0_ZERO=1`, write const 0xBEEF to r0 and `busy_set` on r0 → r0 reads 0 and `busy_vec[0]` stays 0.
- `busy_set` on r5, then `rs_addr`=5 with `rs_use`=1 → `stall`=1. A RAM write of 0x00FF to r5 → `stall` drops in that cycle (`BYPASS=1`) with `rs_data`=0x00FF; the bit is clear the next cycle.
- Same-cycle `busy_set` and write, both on r4 → `busy_vec[4]`=1 afterwards; r4 holds the written value.
- `wr_sel`=6 with `wr_en` on r1 holding 0x0007 → r1 unchanged and `sel_err` high for exactly 1 cycle. Then assert `rst` mid-stall → `busy_vec`=0 and `stall`=0 immediately.
